// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request/response and data-memory signals of the load/store unit.
// The master view belongs to the unit; the slave view to the pipeline and memory around it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        stall;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault, stall,
    output mem_write, mem_address, mem_write_data
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault, stall,
    input  mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: big-endian sub-word extraction on loads, read-modify-write for sub-word
// stores against a word-only memory, plus alignment/range fault checks.
module load_store_unit #(
  parameter logic [31:0] ADDR_BASE    = 32'h7FFF0000,
  parameter logic [31:0] ADDR_LAST    = 32'h7FFFFFFC,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.master lsu_bus
);

  localparam int unsigned RdLat =
      (READ_LATENCY < 1) ? 1 : ((READ_LATENCY > 4) ? 4 : READ_LATENCY);
  localparam logic [1:0]  WaitInit = 2'(RdLat - 1);
  localparam logic [29:0] BaseIdx  = ADDR_BASE[31:2];
  localparam logic [29:0] LastIdx  = ADDR_LAST[31:2];

  typedef enum logic [2:0] {StIdle, StRdWait, StRmwWait, StWr, StResp} state_e;

  state_e      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_rdata_q;
  logic        stall_q;
  logic        mem_write_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [1:0]  offset_q;
  logic        signed_q;
  logic [1:0]  wait_cnt_q;

  logic        accept;
  logic        req_fault;
  logic [29:0] req_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept   = lsu_bus.req_valid && req_ready_q;
  assign req_word = lsu_bus.req_addr[31:2];

  // Fault priority: illegal size, half misalignment, word misalignment, address range.
  always_comb begin
    req_fault = 1'b0;
    if (lsu_bus.req_size == 2'd3) begin
      req_fault = 1'b1;
    end else if (lsu_bus.req_size == 2'd1 && lsu_bus.req_addr[0]) begin
      req_fault = 1'b1;
    end else if (lsu_bus.req_size == 2'd2 && lsu_bus.req_addr[1:0] != 2'd0) begin
      req_fault = 1'b1;
    end else if (req_word < BaseIdx || req_word > LastIdx) begin
      req_fault = 1'b1;
    end
  end

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    rd_byte = 8'h00;
    unique case (offset_q)
      2'd0:    rd_byte = lsu_bus.mem_read_data[31:24];
      2'd1:    rd_byte = lsu_bus.mem_read_data[23:16];
      2'd2:    rd_byte = lsu_bus.mem_read_data[15:8];
      default: rd_byte = lsu_bus.mem_read_data[7:0];
    endcase
    rd_half = offset_q[1] ? lsu_bus.mem_read_data[15:0] : lsu_bus.mem_read_data[31:16];

    case (size_q)
      2'd0:    load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'd1:    load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_ext = lsu_bus.mem_read_data;
    endcase
  end

  always_comb begin
    merged = lsu_bus.mem_read_data;
    if (size_q == 2'd0) begin
      unique case (offset_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (offset_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_fault_q     <= 1'b0;
      resp_rdata_q     <= 32'h0;
      stall_q          <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= 32'h0;
      mem_write_data_q <= 32'h0;
      wdata_q          <= 32'h0;
      size_q           <= 2'd0;
      offset_q         <= 2'd0;
      signed_q         <= 1'b0;
      wait_cnt_q       <= 2'd0;
    end else begin
      // Pulse-style outputs default low; only the transition into RESP or WR raises them.
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_write_q  <= 1'b0;

      case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            wdata_q     <= lsu_bus.req_wdata;
            size_q      <= lsu_bus.req_size;
            offset_q    <= lsu_bus.req_addr[1:0];
            signed_q    <= lsu_bus.req_signed;
            if (req_fault) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
            end else begin
              mem_address_q <= {lsu_bus.req_addr[31:2], 2'b00};
              stall_q       <= 1'b1;
              if (!lsu_bus.req_write) begin
                state_q    <= StRdWait;
                wait_cnt_q <= WaitInit;
              end else if (lsu_bus.req_size == 2'd2) begin
                state_q          <= StWr;
                mem_write_q      <= 1'b1;
                mem_write_data_q <= lsu_bus.req_wdata;
              end else begin
                state_q    <= StRmwWait;
                wait_cnt_q <= WaitInit;
              end
            end
          end
        end

        StRdWait: begin
          if (wait_cnt_q == 2'd0) begin
            state_q      <= StResp;
            stall_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_ext;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end

        StRmwWait: begin
          if (wait_cnt_q == 2'd0) begin
            state_q          <= StWr;
            mem_write_q      <= 1'b1;
            mem_write_data_q <= merged;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end

        StWr: begin
          state_q      <= StResp;
          stall_q      <= 1'b0;
          resp_valid_q <= 1'b1;
        end

        StResp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b0;
          stall_q     <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_bus.req_ready      = req_ready_q;
  assign lsu_bus.resp_valid     = resp_valid_q;
  assign lsu_bus.resp_fault     = resp_fault_q;
  assign lsu_bus.resp_rdata     = resp_rdata_q;
  assign lsu_bus.stall          = stall_q;
  assign lsu_bus.mem_write      = mem_write_q;
  assign lsu_bus.mem_address    = mem_address_q;
  assign lsu_bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance with READ_LATENCY=1, one with 3,
// each backed by a word memory that only returns valid data after the address settles.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit_if bus1 ();
  load_store_unit_if bus3 ();

  load_store_unit #(.READ_LATENCY(1)) u_dut (.clk(clk), .rst(rst), .lsu_bus(bus1));
  load_store_unit #(.READ_LATENCY(3)) u_dut_lat3 (.clk(clk), .rst(rst), .lsu_bus(bus3));

  int          t_sel = 0;
  logic        t_valid = 1'b0;
  logic        t_wr = 1'b0;
  logic [1:0]  t_size = 2'd0;
  logic        t_signed = 1'b0;
  logic [31:0] t_addr = 32'h0;
  logic [31:0] t_wdata = 32'h0;

  assign bus1.req_valid  = t_valid && (t_sel == 0);
  assign bus3.req_valid  = t_valid && (t_sel == 1);
  assign bus1.req_write  = t_wr;
  assign bus3.req_write  = t_wr;
  assign bus1.req_size   = t_size;
  assign bus3.req_size   = t_size;
  assign bus1.req_signed = t_signed;
  assign bus3.req_signed = t_signed;
  assign bus1.req_addr   = t_addr;
  assign bus3.req_addr   = t_addr;
  assign bus1.req_wdata  = t_wdata;
  assign bus3.req_wdata  = t_wdata;

  // Memories: read data is garbage until the address has been stable for the latency.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] last1 = 32'h0;
  logic [31:0] last3 = 32'h0;
  int run1 = 0;
  int run3 = 0;
  int run_now1;
  int run_now3;

  assign run_now1 = (bus1.mem_address == last1) ? run1 + 1 : 1;
  assign run_now3 = (bus3.mem_address == last3) ? run3 + 1 : 1;
  assign bus1.mem_read_data = (run_now1 >= 1) ? mem1[bus1.mem_address[9:2]] : 32'hA5A5A5A5;
  assign bus3.mem_read_data = (run_now3 >= 3) ? mem3[bus3.mem_address[9:2]] : 32'hA5A5A5A5;

  always @(posedge clk) begin
    if (bus1.mem_write) mem1[bus1.mem_address[9:2]] <= bus1.mem_write_data;
    if (bus3.mem_write) mem3[bus3.mem_address[9:2]] <= bus3.mem_write_data;
    last1 <= bus1.mem_address;
    last3 <= bus3.mem_address;
    run1  <= run_now1;
    run3  <= run_now3;
  end

  logic [31:0] ref_mem [2][256];
  exp_t q1[$];
  exp_t q3[$];
  int stall_cnt [2] = '{0, 0};
  int mw_run [2] = '{0, 0};
  int pulses [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic is_fault(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    return (w < (32'h7FFF0000 >> 2)) || (w > (32'h7FFFFFFC >> 2));
  endfunction

  task automatic monitor_step(input int sel, input logic rv, input logic [31:0] rd,
                              input logic flt, input logic stl, input logic mw);
    exp_t e;
    logic empty;
    if (mw) begin
      mw_run[sel]++;
    end else if (mw_run[sel] != 0) begin
      check("mem_write_width", 32'(mw_run[sel]), 32'd1);
      pulses[sel]++;
      mw_run[sel] = 0;
    end
    if (rv) begin
      check("resp_stall_low", {31'd0, stl}, 32'd0);
      empty = (sel == 0) ? (q1.size() == 0) : (q3.size() == 0);
      if (empty) begin
        check("unexpected_resp", {31'd0, rv}, 32'd0);
      end else begin
        e = (sel == 0) ? q1.pop_front() : q3.pop_front();
        check("resp_rdata", rd, e.rdata);
        check("resp_fault", {31'd0, flt}, {31'd0, e.fault});
        check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        check("stall_cycles", 32'(stall_cnt[sel]), 32'(e.lat - 1));
      end
      stall_cnt[sel] = 0;
    end else if (stl) begin
      stall_cnt[sel]++;
    end
    if (rst) stall_cnt[sel] = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_step(0, bus1.resp_valid, bus1.resp_rdata, bus1.resp_fault, bus1.stall,
                   bus1.mem_write);
      monitor_step(1, bus3.resp_valid, bus3.resp_rdata, bus3.resp_fault, bus3.stall,
                   bus3.mem_write);
    end
  end

  task automatic issue(input int sel, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic expect_resp,
                       output int acc);
    exp_t        e;
    logic        ok;
    logic        rdy;
    logic [31:0] old;
    logic [31:0] mask;
    logic [31:0] v;
    int          sh;
    int          rd_lat;
    @(negedge clk);
    t_sel = sel; t_wr = wr; t_size = sz; t_signed = sg; t_addr = a; t_wdata = wd;
    t_valid = 1'b1;
    ok = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rdy = (sel == 0) ? bus1.req_ready : bus3.req_ready;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", {31'd0, rdy}, 32'd1);
      t_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    rd_lat = (sel == 0) ? 1 : 3;
    e.acc = acc;
    e.fault = is_fault(sz, a);
    e.rdata = 32'h0;
    old  = ref_mem[sel][a[9:2]];
    sh   = (sz == 2'd0) ? 8 * (3 - int'(a[1:0])) : (sz == 2'd1) ? 16 * (1 - int'(a[1])) : 0;
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    if (e.fault) begin
      e.lat = 1;
    end else if (wr) begin
      e.lat = (sz == 2'd2) ? 2 : rd_lat + 2;
      if (expect_resp) ref_mem[sel][a[9:2]] = (old & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      e.lat = rd_lat + 1;
      v = (old >> sh) & mask;
      if (sg && sz == 2'd0 && v[7]) v = v | 32'hFFFFFF00;
      if (sg && sz == 2'd1 && v[15]) v = v | 32'hFFFF0000;
      e.rdata = v;
    end
    if (expect_resp) begin
      if (sel == 0) q1.push_back(e);
      else q3.push_back(e);
    end
    @(posedge clk);
    #1 t_valid = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      n = (sel == 0) ? q1.size() : q3.size();
      if (n == 0) break;
      @(negedge clk);
    end
    check("resp_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int acc;
    int acc2;
    int p0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) ref_mem[s][i] = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus1.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus1.resp_valid}, 32'd0);
    check("rst_resp_fault", {31'd0, bus1.resp_fault}, 32'd0);
    check("rst_stall", {31'd0, bus1.stall}, 32'd0);
    check("rst_mem_write", {31'd0, bus1.mem_write}, 32'd0);
    check("rst_resp_rdata", bus1.resp_rdata, 32'h0);
    check("rst_mem_address", bus1.mem_address, 32'h0);
    check("rst_mem_wdata", bus1.mem_write_data, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus1.req_ready}, 32'd1);

    // Word store then load
    p0 = pulses[0];
    issue(0, 1'b1, 2'd2, 1'b0, 32'h7FFF0010, 32'hDEADBEEF, 1'b1, acc);
    wait_done(0);
    check("sw_pulses", 32'(pulses[0] - p0), 32'd1);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h7FFF0010, 32'h0, 1'b1, acc);
    wait_done(0);

    // Sub-word loads with sign/zero extension
    issue(0, 1'b1, 2'd2, 1'b0, 32'h7FFF0020, 32'h80FF7F01, 1'b1, acc);
    issue(0, 1'b0, 2'd0, 1'b1, 32'h7FFF0020, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd0, 1'b0, 32'h7FFF0021, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd1, 1'b1, 32'h7FFF0022, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h7FFF0020, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd0, 1'b1, 32'h7FFF0023, 32'h0, 1'b1, acc);
    wait_done(0);

    // Byte store read-modify-write
    issue(0, 1'b1, 2'd2, 1'b0, 32'h7FFF0030, 32'h11223344, 1'b1, acc);
    wait_done(0);
    p0 = pulses[0];
    issue(0, 1'b1, 2'd0, 1'b0, 32'h7FFF0032, 32'h000000AA, 1'b1, acc);
    wait_done(0);
    check("sb_pulses", 32'(pulses[0] - p0), 32'd1);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h7FFF0030, 32'h0, 1'b1, acc);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h7FFF0030, 32'h0000BEEF, 1'b1, acc);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h7FFF0030, 32'h0, 1'b1, acc);
    wait_done(0);

    // Faults and range boundaries
    p0 = pulses[0];
    issue(0, 1'b0, 2'd2, 1'b0, 32'h7FFF0002, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h7FFF0001, 32'h0, 1'b1, acc);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h80000000, 32'h12345678, 1'b1, acc);
    issue(0, 1'b0, 2'd3, 1'b0, 32'h7FFF0010, 32'h0, 1'b1, acc);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h7FFEFFFC, 32'h12345678, 1'b1, acc);
    wait_done(0);
    check("fault_pulses", 32'(pulses[0] - p0), 32'd0);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h7FFFFFFC, 32'hCAFEF00D, 1'b1, acc);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h7FFFFFFC, 32'h0, 1'b1, acc);
    issue(0, 1'b0, 2'd0, 1'b0, 32'h7FFFFFFF, 32'h0, 1'b1, acc);
    wait_done(0);

    // Reset during RMW_WAIT aborts the store
    issue(0, 1'b1, 2'd2, 1'b0, 32'h7FFF0040, 32'h55667788, 1'b1, acc);
    wait_done(0);
    p0 = pulses[0];
    issue(0, 1'b1, 2'd0, 1'b0, 32'h7FFF0041, 32'h00000099, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_mem_write", {31'd0, bus1.mem_write}, 32'd0);
    check("abort_resp_valid", {31'd0, bus1.resp_valid}, 32'd0);
    check("abort_stall", {31'd0, bus1.stall}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready_in_rst", {31'd0, bus1.req_ready}, 32'd0);
    @(negedge clk);
    check("abort_ready_after", {31'd0, bus1.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("abort_pulses", 32'(pulses[0] - p0), 32'd0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h7FFF0040, 32'h0, 1'b1, acc);
    wait_done(0);

    // READ_LATENCY=3 back-to-back loads
    issue(1, 1'b1, 2'd2, 1'b0, 32'h7FFF0050, 32'h0BADCAFE, 1'b1, acc);
    issue(1, 1'b1, 2'd2, 1'b0, 32'h7FFF0054, 32'h12345678, 1'b1, acc);
    issue(1, 1'b1, 2'd0, 1'b0, 32'h7FFF0057, 32'h000000E1, 1'b1, acc);
    wait_done(1);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h7FFF0050, 32'h0, 1'b1, acc);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h7FFF0054, 32'h0, 1'b1, acc2);
    check("b2b_spacing_1", 32'(acc2 - acc), 32'(3 + 2));
    issue(1, 1'b0, 2'd1, 1'b1, 32'h7FFF0050, 32'h0, 1'b1, acc);
    check("b2b_spacing_2", 32'(acc - acc2), 32'(3 + 2));
    wait_done(1);

    repeat (3) @(negedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the MEM pipeline stage and drives the word-wide data memory.
- Performs byte/halfword lane extraction with sign/zero extension on loads.
- Performs read-modify-write for sub-word stores, because the memory only writes full words.
- Checks alignment and address range, and stalls the pipeline while an access is in flight.

Parameters:
- ADDR_BASE, 32'h7FFF0000, lowest legal data address.
- ADDR_LAST, 32'h7FFFFFFC, highest legal word address; accesses whose word address exceeds it fault.
- READ_LATENCY, 1, cycles from a stable mem_address to a valid mem_read_data (1..4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and faults.
- req_signed  in  1  sign-extend sub-word loads (lb/lh), else zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  misaligned, out-of-range or illegal-size request; valid with resp_valid.
- stall  out  1  high from acceptance until the cycle before resp_valid.
- mem_write  out  1  memory write strobe.
- mem_address  out  32  word-aligned address: {addr[31:2], 2'b00}.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  memory read data.

Behaviour:
- Clocking and reset: single clock domain, rising edge. rst is synchronous and active-high; no asynchronous reset anywhere.
- Reset values: state=IDLE; req_ready=0 while rst is high, then 1; resp_valid, resp_fault, stall and mem_write are 0; resp_rdata, mem_address and mem_write_data are 0.
- Reset mid-operation aborts the access. mem_write is 0 from the first clock edge with rst high, and no resp_valid is produced for the aborted request.
- States: IDLE, RD_WAIT, RMW_WAIT, WR, RESP.
- Request capture: req_ready=1 only in IDLE (and not in reset). A request is accepted on an edge where req_valid&&req_ready, and all req_* fields are registered at acceptance.
- Fault check at acceptance, in priority order:
  1. size==3.
  2. half with addr[0]=1.
  3. word with addr[1:0]!=0.
  4. addr[31:2] outside [ADDR_BASE[31:2], ADDR_LAST[31:2]].
- On a fault: go to RESP with no memory access; mem_write stays 0.
- Load:
  - IDLE to RD_WAIT, with mem_address driven for READ_LATENCY cycles.
  - Sample mem_read_data at the end of the last wait cycle, then go to RESP.
  - resp_valid is asserted READ_LATENCY+1 cycles after acceptance.
- Word store:
  - IDLE to WR: mem_write=1 for exactly one cycle, mem_write_data=req_wdata.
  - Then RESP; resp_valid is asserted 2 cycles after acceptance.
- Sub-word store:
  - IDLE to RMW_WAIT, which reads the word for READ_LATENCY cycles.
  - WR writes the merged word (only the addressed lane replaced), then RESP.
  - Total latency READ_LATENCY+2.
- Byte order is big-endian:
  - Byte offset 0 maps to bits [31:24]; offset 3 maps to [7:0].
  - Half at offset 0 maps to [31:16]; offset 2 maps to [15:0].
- RESP lasts one cycle:
  - resp_valid=1; resp_rdata holds the extended load data, or 0 for stores and faults.
  - Next state is IDLE.
  - There is no backpressure on responses; the consumer must take the pulse.
- stall=1 in RD_WAIT, RMW_WAIT and WR; stall=0 in IDLE and RESP.
- mem_write must be 0 in every state except WR, since the memory acts on level changes.
- mem_address and mem_write_data stay constant throughout RD_WAIT, RMW_WAIT and WR. In IDLE, mem_address holds its last value, with no toggling.
- Back-to-back requests: a new request can be accepted in the IDLE cycle following RESP, giving a minimum spacing of 1 idle cycle.
- Boundary cases:
  - Address 32'h7FFFFFFC is legal.
  - Address 32'h80000000 faults.
  - Address 32'h7FFEFFFC faults.
  - Byte access at 32'h7FFFFFFF is legal.

Test Plan:
1. Reset, then store word 32'hDEADBEEF to 32'h7FFF0010, then load word from the same address. Required: mem_write high for exactly 1 cycle; load resp_rdata=32'hDEADBEEF at acceptance+2 with READ_LATENCY=1; resp_fault=0.
2. With word 32'h80FF7F01 at 32'h7FFF0020: lb at offset 0 gives 32'hFFFFFF80; lbu at offset 1 gives 32'h000000FF; lh at offset 2 gives 32'h00007F01; lhu at offset 0 gives 32'h000080FF.
3. Word 32'h11223344 at 32'h7FFF0030; sb 32'h000000AA at 32'h7FFF0032, then lw. Required: exactly one mem_write pulse, and the load returns 32'h1122AA44.
4. Faults: lw at 32'h7FFF0002, lh at 32'h7FFF0001, sw at 32'h80000000, and size=3. Each gives resp_valid with resp_fault=1 and resp_rdata=0 at acceptance+1, with mem_write never asserted.
5. Assert rst while in RMW_WAIT of a sub-word store. Required: no mem_write, no resp_valid, and memory contents unchanged; req_ready=1 one cycle after rst drops.
6. READ_LATENCY=3 with back-to-back loads. Required: resp_valid at acceptance+4, stall high exactly 3 cycles per load, and the second request accepted the cycle after RESP.
